// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Control FSM for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       retire,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
        S_BRANCH   = 4'd8,  S_ADDIEX  = 4'd9,  S_ADDIWB = 4'd10, S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    // Raw vector (not the enum type) so the unused encodings 12-15 stay representable
    logic [3:0] r_state;
    logic       w_funct_ok;
    logic [2:0] w_rtype_alu;
    logic       w_op_legal;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_rtype_alu = 3'b010;
        case (funct)
            6'b100000: w_rtype_alu = 3'b010;
            6'b100010: w_rtype_alu = 3'b110;
            6'b100100: w_rtype_alu = 3'b000;
            6'b100101: w_rtype_alu = 3'b001;
            6'b101010: w_rtype_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_ADDI, c_OP_J: w_op_legal = 1'b1;
            c_OP_RTYPE: w_op_legal = w_funct_ok;
            default:    w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
                        c_OP_RTYPE:       r_state <= w_funct_ok ? S_EXECUTE : S_FETCH;
                        c_OP_BEQ:         r_state <= S_BRANCH;
                        c_OP_ADDI:        r_state <= S_ADDIEX;
                        c_OP_J:           r_state <= S_JUMP;
                        default:          r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= (opcode == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECUTE:  r_state <= S_ALUWB;
                S_ADDIEX:   r_state <= S_ADDIWB;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Reset overrides the decode so nothing is written or retired during reset
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        retire     = 1'b0;
        illegal_op = 1'b0;
        if (reset_n) begin
            ALUSrcB    = 2'b01;
            ALUControl = 3'b010;
        end else begin
            case (r_state)
                S_FETCH: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = 3'b010;
                    IRWrite    = mem_ready;
                    PCEn       = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = 3'b010;
                    illegal_op = ~w_op_legal;
                end
                S_MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = 3'b010;
                end
                S_MEMREAD:  IorD = 1'b1;
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MEMWRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    retire   = mem_ready;
                end
                S_EXECUTE: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = w_rtype_alu;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = 3'b110;
                    PCSrc      = 2'b01;
                    PCEn       = zero;
                    retire     = 1'b1;
                end
                S_ADDIEX: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = 3'b010;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_JUMP: begin
                    PCSrc  = 2'b10;
                    PCEn   = 1'b1;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed, assertion-checked bench for mips_multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn, retire, illegal_op;
    logic [3:0] state;
    logic [16:0] w_outs;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .retire     (retire),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign w_outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                     ALUSrcB, ALUControl, PCSrc, PCEn, retire, illegal_op};

    function automatic logic [16:0] pk(input logic iord, input logic mw, input logic irw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [2:0] alu, input logic [1:0] pcs,
                                       input logic pce, input logic ret, input logic ill);
        return {iord, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, pce, ret, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input string tag, input logic mr, input logic [3:0] es,
                        input logic [16:0] eo);
        mem_ready = mr;
        #1;
        chk({tag, "_state"}, {28'd0, state}, {28'd0, es});
        chk({tag, "_outs"}, {15'd0, w_outs}, {15'd0, eo});
        tick();
    endtask

    logic [16:0] E_FETCH_IDLE, E_FETCH_GO, E_DECODE, E_DECODE_ILL, E_MEMADR, E_MEMREAD;
    logic [16:0] E_MEMWB, E_MEMWR_WAIT, E_MEMWR_DONE, E_ALUWB, E_ADDIEX, E_ADDIWB, E_JUMP;
    logic [16:0] E_ZERO;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        E_FETCH_IDLE = pk(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,0);
        E_FETCH_GO   = pk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0,0);
        E_DECODE     = pk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,0);
        E_DECODE_ILL = pk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,1);
        E_MEMADR     = pk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0);
        E_MEMREAD    = pk(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
        E_MEMWB      = pk(0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,1,0);
        E_MEMWR_WAIT = pk(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
        E_MEMWR_DONE = pk(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,1,0);
        E_ALUWB      = pk(0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,1,0);
        E_ADDIEX     = pk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0);
        E_ADDIWB     = pk(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1,0);
        E_JUMP       = pk(0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,1,0);
        E_ZERO       = 17'd0;

        reset_n   = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        tick();

        // Reset: FETCH values, no IR/PC load even with mem_ready high
        step("rst_hold", 1'b0, 4'd0, E_FETCH_IDLE);
        step("rst_mr1",  1'b1, 4'd0, E_FETCH_IDLE);
        reset_n = 1'b0;

        // lw, mem_ready tied high: 0,1,2,3,4
        opcode = 6'b100011;
        step("lw_fetch",   1'b1, 4'd0, E_FETCH_GO);
        step("lw_decode",  1'b1, 4'd1, E_DECODE);
        step("lw_memadr",  1'b1, 4'd2, E_MEMADR);
        step("lw_memread", 1'b1, 4'd3, E_MEMREAD);
        step("lw_memwb",   1'b1, 4'd4, E_MEMWB);

        // sw with three wait cycles in MEMWRITE
        opcode = 6'b101011;
        step("sw_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("sw_decode", 1'b1, 4'd1, E_DECODE);
        step("sw_memadr", 1'b1, 4'd2, E_MEMADR);
        step("sw_wait1",  1'b0, 4'd5, E_MEMWR_WAIT);
        step("sw_wait2",  1'b0, 4'd5, E_MEMWR_WAIT);
        step("sw_wait3",  1'b0, 4'd5, E_MEMWR_WAIT);
        step("sw_done",   1'b1, 4'd5, E_MEMWR_DONE);

        // R-type slt
        opcode = 6'b000000;
        funct  = 6'b101010;
        step("slt_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("slt_decode", 1'b1, 4'd1, E_DECODE);
        step("slt_exec",   1'b1, 4'd6, pk(0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0,0));
        step("slt_aluwb",  1'b1, 4'd7, E_ALUWB);

        // R-type sub
        funct = 6'b100010;
        step("sub_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("sub_decode", 1'b1, 4'd1, E_DECODE);
        step("sub_exec",   1'b1, 4'd6, pk(0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0,0));
        step("sub_aluwb",  1'b1, 4'd7, E_ALUWB);

        // R-type or
        funct = 6'b100101;
        step("or_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("or_decode", 1'b1, 4'd1, E_DECODE);
        step("or_exec",   1'b1, 4'd6, pk(0,0,0,0,0,0,1,2'b00,3'b001,2'b00,0,0,0));
        step("or_aluwb",  1'b1, 4'd7, E_ALUWB);

        // Illegal funct, then illegal opcode: DECODE -> FETCH
        funct = 6'b000011;
        step("ilf_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("ilf_decode", 1'b1, 4'd1, E_DECODE_ILL);
        opcode = 6'b111111;
        step("ilo_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("ilo_decode", 1'b1, 4'd1, E_DECODE_ILL);

        // beq taken, then not taken
        opcode = 6'b000100;
        zero   = 1'b1;
        step("beq1_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("beq1_decode", 1'b1, 4'd1, E_DECODE);
        step("beq1_branch", 1'b1, 4'd8, pk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,1,0));
        zero = 1'b0;
        step("beq0_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("beq0_decode", 1'b1, 4'd1, E_DECODE);
        step("beq0_branch", 1'b1, 4'd8, pk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,1,0));

        // addi
        opcode = 6'b001000;
        step("addi_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("addi_decode", 1'b1, 4'd1, E_DECODE);
        step("addi_ex",     1'b1, 4'd9, E_ADDIEX);
        step("addi_wb",     1'b1, 4'd10, E_ADDIWB);

        // Reset while waiting in MEMREAD: no resume, FETCH held while mem_ready low
        opcode = 6'b100011;
        step("lwr_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("lwr_decode", 1'b1, 4'd1, E_DECODE);
        step("lwr_memadr", 1'b1, 4'd2, E_MEMADR);
        step("lwr_wait",   1'b0, 4'd3, E_MEMREAD);
        reset_n = 1'b1;
        step("lwr_inrst",  1'b0, 4'd3, E_FETCH_IDLE);
        reset_n = 1'b0;
        step("lwr_post1",  1'b0, 4'd0, E_FETCH_IDLE);
        step("lwr_post2",  1'b0, 4'd0, E_FETCH_IDLE);

        // Unused encoding 13 recovers to FETCH with all outputs low
        mem_ready = 1'b1;
        force dut.r_state = 4'd13;
        #1;
        release dut.r_state;
        chk("bad13_state", {28'd0, state}, 32'd13);
        chk("bad13_outs", {15'd0, w_outs}, {15'd0, E_ZERO});
        tick();

        // j: 0,1,11
        opcode = 6'b000010;
        step("j_fetch",  1'b1, 4'd0, E_FETCH_GO);
        step("j_decode", 1'b1, 4'd1, E_DECODE);
        step("j_jump",   1'b1, 4'd11, E_JUMP);
        opcode = 6'b000000;
        funct  = 6'b100000;
        step("j_back",   1'b0, 4'd0, E_FETCH_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter: none; all widths are fixed.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  synchronous, active-high reset, sampled on the clk rising edge; asserted = 1 despite the port name.
REQ-004 opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  in  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory handshake: access completes in a cycle where mem_ready = 1.
REQ-008 IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemWrite  out  1  memory write strobe.
REQ-010 IRWrite  out  1  instruction register load enable.
REQ-011 RegDst  out  1  register write address select: 1 = rd, 0 = rt.
REQ-012 MemtoReg  out  1  register write data select: 1 = data register, 0 = ALUOut.
REQ-013 RegWrite  out  1  register file write enable.
REQ-014 ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 ALUSrcB  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-016 ALUControl  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
REQ-017 PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-018 PCEn  out  1  PC load enable.
REQ-019 retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
REQ-020 illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode or R-type funct.
REQ-021 state  out  4  current state encoding, for debug.

Function
REQ-022 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-023 Encodings 12-15 SHALL transition to FETCH on the next edge, with all outputs 0.
REQ-024 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, with the state held while mem_ready=0.
REQ-025 In FETCH, IRWrite=1 and PCEn=1 SHALL be asserted only in the cycle mem_ready=1, after which the FSM moves to DECODE.
REQ-026 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target precompute).
REQ-027 DECODE SHALL branch on opcode: 100011 (lw) and 101011 (sw) -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
REQ-028 In DECODE, any other opcode, or R-type with funct not in {100000, 100010, 100100, 100101, 101010}, SHALL pulse illegal_op and return to FETCH with no register or memory write.
REQ-029 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUControl=010, then go to MEMREAD for lw or MEMWRITE for sw.
REQ-030 MEMREAD SHALL drive IorD=1, hold while mem_ready=0, and go to MEMWB on mem_ready=1.
REQ-031 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1, retire=1, then go to FETCH.
REQ-032 MEMWRITE SHALL drive IorD=1 and MemWrite=1 every cycle until mem_ready=1, asserting retire=1 in that cycle, then go to FETCH.
REQ-033 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, with ALUControl decoded from funct per REQ-016 order (add, sub, and, or, slt), then go to ALUWB.
REQ-034 ALUWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1, retire=1, then go to FETCH.
REQ-035 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=zero (combinational), retire=1, then go to FETCH.
REQ-036 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUControl=010, then go to ADDIWB.
REQ-037 ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1, retire=1, then go to FETCH.
REQ-038 JUMP SHALL drive PCSrc=10, PCEn=1, retire=1, then go to FETCH.
REQ-039 Any output not listed for a state SHALL be 0.
REQ-040 Except PCEn in BRANCH, all outputs SHALL be functions of state only.
REQ-041 Cycle counts with mem_ready constantly 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-042 reset_n=1 at a rising edge SHALL force state=FETCH, including mid-instruction and during a memory wait; no partial instruction is resumed.
REQ-043 While in reset, and in the cycle following it, every output SHALL equal FETCH-state values with IRWrite=0 and PCEn=0 unless mem_ready=1 after reset is released.
REQ-044 illegal_op and retire SHALL be 0 while reset_n=1.

Verification
REQ-045 lw with mem_ready tied 1 -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 in cycle 5 only; retire pulses once.
REQ-046 sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles; retire coincides with mem_ready=1.
REQ-047 beq with zero=1, then beq with zero=0 -> PCEn=1 in BRANCH for the first, 0 for the second; PCSrc=01 in both.
REQ-048 R-type with funct=101010 -> ALUControl=111 in EXECUTE; funct=000011 -> illegal_op pulse, state 1 -> 0, no RegWrite.
REQ-049 reset_n asserted during MEMREAD wait -> state=0 next edge; no RegWrite, MemWrite or retire.
REQ-050 Force state encoding 13 -> FETCH next cycle; j instruction -> PCSrc=10, PCEn=1, total 3 cycles.
